// File: rtl/fix_tx_pkg.sv
// Shared constants for the FIX transmit path: serializer FSM state codes and
// the ASCII bytes used when framing fields and the checksum trailer.
package fix_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t TAG    = 3'd1;
    localparam state_t EQ     = 3'd2;
    localparam state_t VALUE  = 3'd3;
    localparam state_t FSOH   = 3'd4;
    localparam state_t CK_TAG = 3'd5;
    localparam state_t CK_DIG = 3'd6;
    localparam state_t CK_SOH = 3'd7;

    localparam logic [7:0]  SOH        = 8'h01;
    localparam logic [7:0]  EQ_CHAR    = 8'h3D;
    localparam logic [7:0]  ZERO_CHAR  = 8'h30;
    localparam logic [23:0] CK_TAG_STR = {"1", "0", "="};

endpackage

// File: rtl/fix_msg_serializer_bin2ascii.sv
// Registered 8-bit binary to three ASCII decimal digits ("000".."255"),
// hundreds digit in the top byte; one cycle of latency.
module bin2ascii (
    input  logic        clk,
    input  logic [7:0]  bin,
    output logic [23:0] ascii
);
    import fix_tx_pkg::*;

    function automatic logic [23:0] to_digits(input logic [7:0] b);
        logic [7:0] h;
        logic [7:0] t;
        logic [7:0] u;
        h = b / 8'd100;
        t = (b / 8'd10) % 8'd10;
        u = b % 8'd10;
        return {ZERO_CHAR + h, ZERO_CHAR + t, ZERO_CHAR + u};
    endfunction

    // stage p1: digits registered
    always_ff @(posedge clk) begin
        ascii <= to_digits(bin);
    end

endmodule

// File: rtl/fix_msg_serializer.sv
// Serialises tag/value fields as "tag=value<SOH>" bytes and closes each
// message with the "10=ddd<SOH>" checksum trailer.
module fix_msg_serializer #(
    parameter int         TAG_WIDTH   = 32,
    parameter int         VALUE_WIDTH = 256,
    parameter logic [7:0] SOH         = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   field_valid_i,
    output logic                   field_ready_o,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    input  logic [1:0]             tag_len_m1_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    input  logic [4:0]             value_len_m1_i,
    input  logic                   last_i,
    output logic [7:0]             data_o,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic                   msg_done_o,
    output logic [7:0]             checksum_o,
    output logic                   busy_o
);
    import fix_tx_pkg::*;

    localparam int TAG_CHARS = TAG_WIDTH / 8;
    localparam int VAL_CHARS = VALUE_WIDTH / 8;

    state_t                 state;
    logic [4:0]             idx;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [VALUE_WIDTH-1:0] value_r;
    logic [1:0]             tag_len_r;
    logic [4:0]             val_len_r;
    logic                   last_r;
    logic [7:0]             acc;
    logic [23:0]            ck_digits_p1;
    logic [7:0]             tag_bytes [TAG_CHARS];
    logic [7:0]             val_bytes [VAL_CHARS];
    logic [4:0]             last_idx;
    logic                   at_last;
    logic                   xfer;
    logic                   body_byte;

    assign field_ready_o = (state == IDLE);
    assign data_valid_o  = (state != IDLE);
    assign xfer          = data_valid_o & data_ready_i;
    assign body_byte     = (state == TAG) || (state == EQ) || (state == VALUE) || (state == FSOH);

    always_comb begin
        for (int i = 0; i < TAG_CHARS; i++) tag_bytes[i] = tag_r[TAG_WIDTH-1-8*i -: 8];
        for (int i = 0; i < VAL_CHARS; i++) val_bytes[i] = value_r[VALUE_WIDTH-1-8*i -: 8];
    end

    always_comb begin
        last_idx = 5'd0;
        case (state)
            TAG:            last_idx = {3'b000, tag_len_r};
            VALUE:          last_idx = val_len_r;
            CK_TAG, CK_DIG: last_idx = 5'd2;
            default:        last_idx = 5'd0;
        endcase
    end
    assign at_last = (idx == last_idx);

    always_comb begin
        data_o = 8'h00;
        case (state)
            TAG:    data_o = tag_bytes[idx[1:0]];
            EQ:     data_o = EQ_CHAR;
            VALUE:  data_o = val_bytes[idx];
            FSOH:   data_o = SOH;
            CK_TAG: data_o = (idx[1:0] == 2'd0) ? CK_TAG_STR[23:16] :
                             (idx[1:0] == 2'd1) ? CK_TAG_STR[15:8] : CK_TAG_STR[7:0];
            CK_DIG: data_o = (idx[1:0] == 2'd0) ? ck_digits_p1[23:16] :
                             (idx[1:0] == 2'd1) ? ck_digits_p1[15:8] : ck_digits_p1[7:0];
            CK_SOH: data_o = SOH;
            default: data_o = 8'h00;
        endcase
    end

    // acc stops moving once the trailer starts, so the digits settle during CK_TAG
    bin2ascii u_bin2ascii (
        .clk   (clk),
        .bin   (acc),
        .ascii (ck_digits_p1)
    );

    always_ff @(posedge clk) begin
        if (field_ready_o && field_valid_i) begin
            tag_r     <= tag_i;
            value_r   <= value_i;
            tag_len_r <= tag_len_m1_i;
            val_len_r <= value_len_m1_i;
            last_r    <= last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 5'd0;
            acc        <= 8'h00;
            busy_o     <= 1'b0;
            msg_done_o <= 1'b0;
            checksum_o <= 8'h00;
        end else begin
            msg_done_o <= 1'b0;
            if (state == IDLE) begin
                if (field_valid_i) begin
                    state  <= TAG;
                    idx    <= 5'd0;
                    busy_o <= 1'b1;
                end
            end else if (xfer) begin
                if (body_byte) acc <= acc + data_o;
                idx <= at_last ? 5'd0 : idx + 5'd1;
                case (state)
                    TAG:    if (at_last) state <= EQ;
                    EQ:     state <= VALUE;
                    VALUE:  if (at_last) state <= FSOH;
                    FSOH:   state <= last_r ? CK_TAG : IDLE;
                    CK_TAG: if (at_last) state <= CK_DIG;
                    CK_DIG: if (at_last) state <= CK_SOH;
                    CK_SOH: begin
                        state      <= IDLE;
                        msg_done_o <= 1'b1;
                        checksum_o <= acc;
                        acc        <= 8'h00;
                        busy_o     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fix_msg_serializer.sv
// Bench for fix_msg_serializer: directed FIX messages plus random ones, each
// predicted as a byte string with its mod-256 trailer and scoreboarded.
module tb_fix_msg_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         field_valid_i;
    logic         field_ready_o;
    logic [31:0]  tag_i;
    logic [1:0]   tag_len_m1_i;
    logic [255:0] value_i;
    logic [4:0]   value_len_m1_i;
    logic         last_i;
    logic [7:0]   data_o;
    logic         data_valid_o;
    logic         data_ready_i;
    logic         msg_done_o;
    logic [7:0]   checksum_o;
    logic         busy_o;

    always #5 clk = ~clk;

    fix_msg_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .field_valid_i  (field_valid_i),
        .field_ready_o  (field_ready_o),
        .tag_i          (tag_i),
        .tag_len_m1_i   (tag_len_m1_i),
        .value_i        (value_i),
        .value_len_m1_i (value_len_m1_i),
        .last_i         (last_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .msg_done_o     (msg_done_o),
        .checksum_o     (checksum_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic [31:0]  tag;
        logic [1:0]   tl;
        logic [255:0] val;
        logic [4:0]   vl;
        logic         last;
    } fld_t;

    fld_t       fq[$];
    logic [7:0] eq[$];
    logic [7:0] ckq[$];
    int         msum = 0;
    int         done_exp = 0;
    int         done_seen = 0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        eq.push_back(b);
        msum += int'(b);
    endtask

    // Reference: field text, then for the last field the trailer over the body sum
    task automatic add_field(input logic [31:0] tg, input logic [1:0] tl,
                             input logic [255:0] v, input logic [4:0] vl, input logic lst);
        fld_t f;
        int   d;
        f.tag = tg; f.tl = tl; f.val = v; f.vl = vl; f.last = lst;
        fq.push_back(f);
        for (int i = 0; i <= int'(tl); i++) push_byte(8'(tg >> (24 - 8 * i)));
        push_byte(8'h3D);
        for (int i = 0; i <= int'(vl); i++) push_byte(8'(v >> (248 - 8 * i)));
        push_byte(8'h01);
        if (lst) begin
            d = msum % 256;
            eq.push_back(8'h31); eq.push_back(8'h30); eq.push_back(8'h3D);
            eq.push_back(8'(48 + d / 100));
            eq.push_back(8'(48 + (d / 10) % 10));
            eq.push_back(8'(48 + d % 10));
            eq.push_back(8'h01);
            ckq.push_back(8'(d));
            done_exp++;
            msum = 0;
        end
    endtask

    task automatic run(input int bp_pct, input bit force_bp);
        int         cyc = 0;
        bit         stall = 0;
        logic [7:0] held = 8'h00;
        int         bp_left = 0;
        bit         bp_used = 0;
        bit         first = 1;
        fld_t       f;
        while (!(fq.size() == 0 && eq.size() == 0 && done_seen == done_exp) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (msg_done_o) begin
                done_seen++;
                if (ckq.size() > 0) chk("checksum", {24'b0, checksum_o}, {24'b0, ckq.pop_front()});
                else chk("spurious_done", {31'b0, msg_done_o}, 32'd0);
                chk("busy_clear", {31'b0, busy_o}, 32'd0);
            end
            if (stall) chk("hold", {23'b0, data_valid_o, data_o}, {23'b0, 1'b1, held});
            if (force_bp && !bp_used && data_valid_o && data_o == 8'h44) begin
                bp_left = 3;
                bp_used = 1;
            end
            if (bp_left > 0) begin
                data_ready_i = 1'b0;
                bp_left--;
            end else begin
                data_ready_i = ($urandom_range(99) >= bp_pct);
            end
            stall = data_valid_o && !data_ready_i;
            held  = data_o;
            if (data_valid_o) chk("ready_excl", {31'b0, field_ready_o}, 32'd0);
            if (data_valid_o && data_ready_i) begin
                if (eq.size() > 0) chk("byte", {24'b0, data_o}, {24'b0, eq.pop_front()});
                else chk("extra_byte", {31'b0, data_valid_o}, 32'd0);
            end
            field_valid_i = 1'b0;
            if (fq.size() > 0 && field_ready_o) begin
                f = fq.pop_front();
                tag_i = f.tag; tag_len_m1_i = f.tl; value_i = f.val;
                value_len_m1_i = f.vl; last_i = f.last;
                field_valid_i = 1'b1;
                if (!first) chk("busy_hold", {31'b0, busy_o}, 32'd1);
                first = f.last;
            end
        end
        if (cyc >= 5000) chk("timeout_left", eq.size(), 32'd0);
        field_valid_i = 1'b0;
        data_ready_i  = 1'b1;
        chk("done_count", done_seen, done_exp);
    endtask

    initial begin
        int         n;
        int         cyc;
        logic [31:0]  tg;
        logic [255:0] v;
        rst = 1'b1;
        field_valid_i = 1'b0; tag_i = '0; tag_len_m1_i = '0; value_i = '0;
        value_len_m1_i = '0; last_i = 1'b0; data_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", {24'b0, data_o}, 32'd0);
        chk("rst_valid", {31'b0, data_valid_o}, 32'd0);
        chk("rst_done", {31'b0, msg_done_o}, 32'd0);
        chk("rst_checksum", {24'b0, checksum_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_ready", {31'b0, field_ready_o}, 32'd1);
        rst = 1'b0;

        add_field({"35", 16'h0}, 2'd1, {"D", 248'h0}, 5'd0, 1'b1);
        run(0, 0);
        add_field({"35", 16'h0}, 2'd1, {"D", 248'h0}, 5'd0, 1'b1);
        run(0, 1);
        add_field({"58", 16'h0}, 2'd1, {32{8'h7A}}, 5'd31, 1'b1);
        run(0, 0);
        add_field({"9", 24'h0}, 2'd0, {"HH", 240'h0}, 5'd1, 1'b1);
        run(0, 0);
        chk("pad_checksum", {24'b0, checksum_o}, 32'h07);
        add_field({"8", 24'h0}, 2'd0, {"FIX.4.2", 200'h0}, 5'd6, 1'b0);
        add_field({"35", 16'h0}, 2'd1, {"D", 248'h0}, 5'd0, 1'b1);
        add_field({"35", 16'h0}, 2'd1, {"D", 248'h0}, 5'd0, 1'b1);
        run(0, 0);

        repeat (20) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                tg = $urandom;
                for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
                add_field(tg, 2'($urandom_range(0, 3)), v, 5'($urandom_range(0, 31)), k == n - 1);
            end
        end
        run(30, 0);

        // abandon a message in the middle of its value bytes
        @(negedge clk);
        tag_i = {"35", 16'h0}; tag_len_m1_i = 2'd1; value_i = {32{8'h7A}};
        value_len_m1_i = 5'd31; last_i = 1'b1; data_ready_i = 1'b1;
        field_valid_i = 1'b1;
        @(negedge clk);
        field_valid_i = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            if (data_valid_o) n++;
            if (n < 6) @(negedge clk);
            cyc++;
        end
        chk("mid_value_reached", n, 32'd6);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, data_valid_o}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'b0, field_ready_o}, 32'd1);
        rst = 1'b0;
        eq.delete();
        ckq.delete();
        msum = 0;
        add_field({"35", 16'h0}, 2'd1, {"D", 248'h0}, 5'd0, 1'b1);
        run(0, 0);
        chk("after_rst_checksum", {24'b0, checksum_o}, 32'hEA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
